// File: rtl/switch_gen_pkg.sv
// Shared definitions for the switching-generator data unit:
// width helpers, the burst FSM state type and the cfg target encoding.
package switch_gen_pkg;

  // Select-bus width: max(1, clog2(n)).
  function automatic int sel_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // cfg_tgt code that addresses the state vector. Codes below it address
  // matrices and codes above it are invalid.
  function automatic int tgt_state_code(input int num_mat);
    return num_mat;
  endfunction

  // Burst controller states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fsm_state_e;

endpackage

// File: rtl/gf2_mat_vec.sv
// Combinational M x M matrix times M-bit vector over GF(2).
// Output bit r is the parity of (row r AND vector).
module gf2_mat_vec #(
  parameter int M = 8
) (
  input  logic [M-1:0][M-1:0] i_mat,
  input  logic [M-1:0]        i_vec,
  output logic [M-1:0]        o_vec
);

  genvar gi;
  generate
    for (gi = 0; gi < M; gi++) begin : g_row
      assign o_vec[gi] = ^(i_mat[gi] & i_vec);
    end
  endgenerate

endmodule

// File: rtl/switch_data_unit.sv
// Switching-generator data unit: an M-bit GF(2) state advanced per step by
// one of NUM_MAT programmable matrices, with a row-wise config port, an
// IDLE/RUN/DONE burst controller and a registered output bit with valid.
// Optional build macro: ZERO_GUARD_EN (refuse steps that would reach the
// all-zero state; flag err and end the burst instead).
module switch_data_unit
  import switch_gen_pkg::*;
#(
  parameter int M       = 8,
  parameter int NUM_MAT = 2,
  parameter int LEN_W   = 16,
  localparam int SEL_W  = sel_width(NUM_MAT),
  localparam int ROW_W  = $clog2(M)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [SEL_W:0]   cfg_tgt,
  input  logic [ROW_W-1:0] cfg_row,
  input  logic [M-1:0]     cfg_data,
  input  logic             start,
  input  logic [LEN_W-1:0] burst_len,
  input  logic             step_en,
  input  logic [SEL_W-1:0] sel,
  output logic             out,
  output logic             out_valid,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam logic [SEL_W:0] TGT_STATE_L = (SEL_W+1)'(tgt_state_code(NUM_MAT));

  fsm_state_e r_fsm;
  fsm_state_e w_fsm_next;

  logic [M-1:0]         r_state_vec;
  logic [LEN_W-1:0]     r_cnt;
  logic                 r_out;
  logic                 r_out_valid;
  logic                 r_done;
  logic                 r_err;

  logic [NUM_MAT*M*M-1:0] w_mat_flat;
  logic [M-1:0][M-1:0]    w_mat_sel;
  logic [M-1:0]           w_next;

  logic w_cfg_fire;
  logic w_row_bad;
  logic w_sel_bad;
  logic [SEL_W-1:0] w_sel_eff;
  logic w_mat_we;
  logic w_state_we;
  logic w_cfg_bad;
  logic w_step;
  logic w_commit;
  logic w_lock;

  // ---------------------------------------------------------------------
  // Config decode. Words are only taken while idle; bad targets are
  // swallowed (accepted) and flagged.
  // ---------------------------------------------------------------------
  assign cfg_ready  = (r_fsm == IDLE);
  assign w_cfg_fire = cfg_valid && cfg_ready;

  generate
    if ((1 << ROW_W) > M) begin : g_row_chk
      assign w_row_bad = (cfg_row >= ROW_W'(M));
    end else begin : g_row_full
      assign w_row_bad = 1'b0;
    end
  endgenerate

  assign w_mat_we   = w_cfg_fire && (cfg_tgt < TGT_STATE_L) && !w_row_bad;
  assign w_state_we = w_cfg_fire && (cfg_tgt == TGT_STATE_L);
  assign w_cfg_bad  = w_cfg_fire &&
                      ((cfg_tgt > TGT_STATE_L) || ((cfg_tgt < TGT_STATE_L) && w_row_bad));

  // ---------------------------------------------------------------------
  // Matrix storage: one register per row, packed into a flat bus where
  // matrix k row r lives at bits [(k*M + r)*M +: M].
  // ---------------------------------------------------------------------
  genvar gk, gr;
  generate
    for (gk = 0; gk < NUM_MAT; gk++) begin : g_mat
      for (gr = 0; gr < M; gr++) begin : g_row
        logic [M-1:0] r_row;
        // Row register: cleared on reset, loaded by a matching config word.
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            r_row <= '0;
          end else if (w_mat_we && (cfg_tgt == (SEL_W+1)'(gk)) &&
                       (cfg_row == ROW_W'(gr))) begin
            r_row <= cfg_data;
          end
        end
        assign w_mat_flat[(gk*M + gr)*M +: M] = r_row;
      end
    end
  endgenerate

  // ---------------------------------------------------------------------
  // Step datapath: out-of-range selects fall back to matrix 0.
  // ---------------------------------------------------------------------
  generate
    if ((1 << SEL_W) > NUM_MAT) begin : g_sel_chk
      assign w_sel_bad = (sel >= SEL_W'(NUM_MAT));
    end else begin : g_sel_full
      assign w_sel_bad = 1'b0;
    end
  endgenerate

  assign w_sel_eff = w_sel_bad ? '0 : sel;
  assign w_mat_sel = w_mat_flat[int'(w_sel_eff)*M*M +: M*M];

  gf2_mat_vec #(.M(M)) u_mat_vec (
    .i_mat (w_mat_sel),
    .i_vec (r_state_vec),
    .o_vec (w_next)
  );

  assign w_step = (r_fsm == RUN) && step_en;

`ifdef ZERO_GUARD_EN
  // A step landing on the all-zero state would lock the generator up;
  // such a step is refused and terminates the burst.
  assign w_lock   = w_step && (w_next == '0);
  assign w_commit = w_step && (w_next != '0);
`else
  assign w_lock   = 1'b0;
  assign w_commit = w_step;
`endif

  // ---------------------------------------------------------------------
  // Burst FSM.
  // ---------------------------------------------------------------------
  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fsm <= IDLE;
    end else begin
      r_fsm <= w_fsm_next;
    end
  end

  // Next-state logic: a zero-length burst goes straight to DONE; the step
  // that consumes the last count also ends the burst.
  always_comb begin
    w_fsm_next = r_fsm;
    unique case (r_fsm)
      IDLE: begin
        if (start) begin
          w_fsm_next = (burst_len == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (w_lock) begin
          w_fsm_next = DONE;
        end else if (w_commit && (r_cnt == LEN_W'(1))) begin
          w_fsm_next = DONE;
        end
      end
      DONE:    w_fsm_next = IDLE;
      default: w_fsm_next = IDLE;
    endcase
  end

  // Remaining-step counter: loaded on burst start, decremented per step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if ((r_fsm == IDLE) && start && (burst_len != '0)) begin
      r_cnt <= burst_len;
    end else if (w_commit) begin
      r_cnt <= r_cnt - LEN_W'(1);
    end
  end

  // State vector: config writes while idle, matrix transform while running.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state_vec <= '0;
    end else if (w_state_we) begin
      r_state_vec <= cfg_data;
    end else if (w_commit) begin
      r_state_vec <= w_next;
    end
  end

  // Output bit and valid: one clock after the step; out holds when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out       <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= w_commit;
      if (w_commit) begin
        r_out <= w_next[0];
      end
    end
  end

  // Completion pulse, registered so it follows the final out_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_done <= 1'b0;
    end else begin
      r_done <= (r_fsm == DONE);
    end
  end

  // Sticky error: bad config word, bad select on a step, or lock-up.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else if (w_cfg_bad || (w_step && w_sel_bad) || w_lock) begin
      r_err <= 1'b1;
    end
  end

  assign out       = r_out;
  assign out_valid = r_out_valid;
  assign busy      = (r_fsm == RUN);
  assign done      = r_done;
  assign err       = r_err;

endmodule

// File: tb/tb_switch_data_unit.sv
// Self-checking bench for switch_data_unit (M=4, NUM_MAT=3) against a
// behavioural GF(2) model; honours ZERO_GUARD_EN when defined.
module tb_switch_data_unit;

  localparam int M  = 4;
  localparam int NM = 3;
  localparam int LW = 8;
  localparam int SW = 2;
  localparam int RW = 2;
`ifdef ZERO_GUARD_EN
  localparam bit ZG = 1'b1;
`else
  localparam bit ZG = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cfg_valid = 1'b0;
  logic          cfg_ready;
  logic [SW:0]   cfg_tgt = '0;
  logic [RW-1:0] cfg_row = '0;
  logic [M-1:0]  cfg_data = '0;
  logic          start = 1'b0;
  logic [LW-1:0] burst_len = '0;
  logic          step_en = 1'b0;
  logic [SW-1:0] sel = '0;
  logic          out_bit, out_valid, busy, done, err;

  int n_tests = 0;
  int n_fail  = 0;

  logic [M-1:0] m_mat [NM][M];
  logic [M-1:0] m_state;
  logic         m_err;

  switch_data_unit #(.M(M), .NUM_MAT(NM), .LEN_W(LW)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_tgt(cfg_tgt),
    .cfg_row(cfg_row), .cfg_data(cfg_data),
    .start(start), .burst_len(burst_len), .step_en(step_en), .sel(sel),
    .out(out_bit), .out_valid(out_valid), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [M-1:0] model_next(input int k);
    logic [M-1:0] n;
    for (int r = 0; r < M; r++) n[r] = (($countones(m_mat[k][r] & m_state) % 2) == 1);
    return n;
  endfunction

  task automatic model_reset();
    m_state = '0;
    m_err   = 1'b0;
    for (int k = 0; k < NM; k++)
      for (int r = 0; r < M; r++) m_mat[k][r] = '0;
  endtask

  task automatic cfg_write(input int tgt, input int row, input logic [M-1:0] data);
    check("cfg_ready_idle", cfg_ready, 1);
    cfg_valid = 1'b1;
    cfg_tgt   = (SW+1)'(tgt);
    cfg_row   = RW'(row);
    cfg_data  = data;
    if (tgt == NM)      m_state = data;
    else if (tgt < NM)  m_mat[tgt][row] = data;
    else                m_err = 1'b1;
    tick();
    cfg_valid = 1'b0;
    $display("[TB] cfg tgt=%0d row=%0d data=%h err=%0b", tgt, row, data, err);
    check("cfg_err", err, m_err);
  endtask

  // sel_mode: 0 fixed sel, 1 alternate 0/1, 2 random 0..3.
  // stall_mode: 0 none, 1 three-cycle stall at step 2 with cfg during RUN, 2 random.
  task automatic run_burst(input int len, input int sel_mode, input int fixed_sel,
                           input int stall_mode, input bit do_cfg, input logic [M-1:0] cfg_st);
    int remaining, step_idx, stalled, guard, s;
    bit en, aborted;
    logic [M-1:0] nxt;
    if (do_cfg) begin
      cfg_valid = 1'b1; cfg_tgt = (SW+1)'(NM); cfg_row = '0; cfg_data = cfg_st;
      m_state = cfg_st;
    end
    start = 1'b1; burst_len = LW'(len);
    tick();
    start = 1'b0; cfg_valid = 1'b0;
    $display("[TB] burst len=%0d sel_mode=%0d stall_mode=%0d cfg=%0b", len, sel_mode, stall_mode, do_cfg);
    if (len == 0) begin
      check("zl_busy", busy, 0);
      check("zl_ov", out_valid, 0);
    end else begin
      check("start_busy", busy, 1);
      check("start_cfg_ready", cfg_ready, 0);
      remaining = len; step_idx = 0; stalled = 0; guard = 0; aborted = 1'b0;
      while (remaining > 0 && !aborted && guard < 200) begin
        guard++;
        en = 1'b1;
        cfg_valid = 1'b0;
        if (stall_mode == 1 && step_idx == 2 && stalled < 3) begin
          en = 1'b0; stalled++;
          cfg_valid = 1'b1; cfg_tgt = '0; cfg_row = '0; cfg_data = '1;
        end else if (stall_mode == 2) begin
          en = ($urandom_range(0, 3) != 0);
        end
        if (sel_mode == 0)      s = fixed_sel;
        else if (sel_mode == 1) s = step_idx % 2;
        else                    s = $urandom_range(0, 3);
        step_en = en; sel = SW'(s);
        tick();
        if (en) begin
          if (s >= NM) begin m_err = 1'b1; s = 0; end
          nxt = model_next(s);
          if (ZG && nxt == '0) begin
            m_err = 1'b1; aborted = 1'b1;
            check("lock_ov", out_valid, 0);
          end else begin
            m_state = nxt;
            remaining--; step_idx++;
            check("step_ov", out_valid, 1);
            check("step_out", out_bit, nxt[0]);
            if (remaining > 0) check("busy_mid", busy, 1);
          end
          check("state", dut.r_state_vec, m_state);
        end else begin
          check("stall_ov", out_valid, 0);
          check("stall_cfg_ready", cfg_ready, 0);
        end
        check("err", err, m_err);
      end
      if (guard >= 200) check("burst_timeout", 0, 1);
      step_en = 1'b0; cfg_valid = 1'b0;
      check("end_busy", busy, 0);
    end
    tick();
    check("done_pulse", done, 1);
    check("done_ov", out_valid, 0);
    tick();
    check("done_clear", done, 0);
    check("idle_cfg_ready", cfg_ready, 1);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic load_id_shift();
    for (int r = 0; r < M; r++) begin
      cfg_write(0, r, M'(1 << r));
      cfg_write(1, r, M'(1 << ((r + 1) % M)));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation timed out");
    $fatal(1, "timeout");
  end

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_out", out_bit, 0);
    check("rst_ov", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_cfg_ready", cfg_ready, 1);
    rst_n = 1'b1;
    tick();

    // Identity vs shift, then mixed select.
    load_id_shift();
    cfg_write(NM, 0, 4'b0001);
    run_burst(4, 0, 1, 0, 1'b0, '0);
    check("shift_final", dut.r_state_vec, 4'b0001);
    run_burst(4, 1, 0, 0, 1'b0, '0);
    check("mixed_final", dut.r_state_vec, 4'b0100);

    // Stall with config lockout, zero-length burst.
    run_burst(5, 2, 0, 1, 1'b0, '0);
    run_burst(0, 0, 0, 0, 1'b0, '0);

    // Reset in the middle of a burst.
    cfg_write(NM, 0, 4'b0001);
    start = 1'b1; burst_len = LW'(4);
    tick();
    start = 1'b0; step_en = 1'b1; sel = '0;
    tick();
    check("mid_ov", out_valid, 1);
    check("mid_out", out_bit, 1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_out", out_bit, 0);
    check("mid_rst_ov", out_valid, 0);
    check("mid_rst_busy", busy, 0);
    step_en = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
    run_burst(1, 0, 0, 0, 1'b0, '0);

    // Zero-state step (guarded or propagated by build).
    apply_reset();
    cfg_write(NM, 0, 4'b0001);
    run_burst(2, 0, 1, 0, 1'b0, '0);

    // Error cases: bad target, bad select.
    apply_reset();
    load_id_shift();
    cfg_write(NM, 0, 4'b0010);
    cfg_write(5, 1, 4'hF);
    run_burst(3, 0, 3, 0, 1'b0, '0);

    // Randomized bursts.
    apply_reset();
    for (int it = 0; it < 24; it++) begin
      if ($urandom_range(0, 1) == 1) begin
        cfg_write($urandom_range(0, NM), $urandom_range(0, M - 1), M'($urandom));
        cfg_write($urandom_range(0, NM - 1), $urandom_range(0, M - 1), M'($urandom));
      end
      run_burst($urandom_range(0, 6), 2, 0, 2, 1'($urandom_range(0, 1)), M'($urandom_range(1, 15)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
